// File: rtl/signature_test_sequencer.sv
// Two-phase signature self-test sequencer: clears the DUT, sweeps its stimulus,
// compacts its outputs into a per-phase signature and reports a pass/fail verdict.
module signature_test_sequencer #(
    parameter int STIM_W      = 8,
    parameter int CLR_CYCLES  = 2,
    parameter int DUT_LATENCY = 0
) (
    input  logic                clk_i,
    input  logic                clear_i,
    input  logic                start_i,
    input  logic [STIM_W-1:0]   seed_a_i,
    input  logic [STIM_W-1:0]   seed_b_i,
    input  logic [2*STIM_W-1:0] golden_a_i,
    input  logic [2*STIM_W-1:0] golden_b_i,
    input  logic [STIM_W-1:0]   dut_out_i,
    output logic                dut_clear_o,
    output logic [STIM_W-1:0]   stimulus_o,
    output logic [2*STIM_W-1:0] signature_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                pass_o,
    output logic [1:0]          fail_phase_o
);

    // state   | meaning
    // S_IDLE  | waiting for start after reset
    // S_CLR   | DUT held in clear, stimulus and signature zeroed
    // S_RUN   | stimulus sweeps 0..max, one value per cycle
    // S_DRAIN | waiting for the last DUT outputs to emerge from its pipeline
    // S_CHECK | signature compared against the golden value of the phase
    // S_DONE  | verdict valid, waiting for the next start
    typedef enum logic [2:0] {S_IDLE, S_CLR, S_RUN, S_DRAIN, S_CHECK, S_DONE} state_t;

    localparam int SIG_W = 2 * STIM_W;
    localparam int CNT_W = 32;
    localparam logic [CNT_W-1:0] CLR_LOAD   = CNT_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LOAD   = CNT_W'((1 << STIM_W) - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'((DUT_LATENCY > 0) ? DUT_LATENCY - 1 : 0);
    localparam logic [STIM_W-1:0] STIM_MAX  = {STIM_W{1'b1}};

    state_t             state_q, state_d;
    logic               phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STIM_W-1:0]  stim_q, stim_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic [1:0]         fail_q, fail_d;
    logic               pass_q, pass_d;

    logic [STIM_W-1:0]  seed;
    logic [SIG_W-1:0]   golden;
    logic [STIM_W-1:0]  sum_lo;
    logic [SIG_W-1:0]   sig_upd;
    logic               run_valid;
    logic               acc_en;

    assign seed      = phase_q ? seed_b_i : seed_a_i;
    assign golden    = phase_q ? golden_b_i : golden_a_i;
    assign run_valid = (state_q == S_RUN);
    assign sum_lo    = sig_q[STIM_W-1:0] + (seed ^ dut_out_i);
    assign sig_upd   = {sig_q[SIG_W-2:STIM_W], sum_lo, sig_q[SIG_W-1]};

    // The accumulate enable follows the stimulus through the DUT pipeline.
    generate
        if (DUT_LATENCY == 0) begin : g_no_lat
            assign acc_en = run_valid;
        end else begin : g_lat
            logic [DUT_LATENCY-1:0] valid_sr_q;
            always_ff @(posedge clk_i or posedge clear_i) begin
                if (clear_i) valid_sr_q <= '0;
                else         valid_sr_q <= (valid_sr_q << 1) | DUT_LATENCY'(run_valid);
            end
            assign acc_en = valid_sr_q[DUT_LATENCY-1];
        end
    endgenerate

    always_ff @(posedge clk_i or posedge clear_i) begin
        if (clear_i) begin
            state_q <= S_IDLE;
            phase_q <= 1'b0;
            cnt_q   <= '0;
            stim_q  <= '0;
            sig_q   <= '0;
            fail_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            stim_q  <= stim_d;
            sig_q   <= sig_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        stim_d  = stim_q;
        sig_d   = acc_en ? sig_upd : sig_q;
        fail_d  = fail_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_CLR;
                    phase_d = 1'b0;
                    cnt_d   = CLR_LOAD;
                    stim_d  = '0;
                    sig_d   = '0;
                    fail_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            S_CLR: begin
                if (cnt_q == '0) begin
                    state_d = S_RUN;
                    cnt_d   = RUN_LOAD;
                end
            end
            S_RUN: begin
                if (stim_q != STIM_MAX) stim_d = stim_q + 1'b1;
                if (cnt_q == '0) begin
                    if (DUT_LATENCY == 0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DRAIN;
                        cnt_d   = DRAIN_LOAD;
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (sig_q != golden) fail_d[phase_q] = 1'b1;
                if (!phase_q) begin
                    state_d = S_CLR;
                    phase_d = 1'b1;
                    cnt_d   = CLR_LOAD;
                    stim_d  = '0;
                    sig_d   = '0;
                end else begin
                    state_d = S_DONE;
                    pass_d  = (fail_d == 2'b00);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign dut_clear_o  = (state_q == S_CLR);
    assign busy_o       = (state_q == S_CLR) || (state_q == S_RUN) ||
                          (state_q == S_DRAIN) || (state_q == S_CHECK);
    assign done_o       = (state_q == S_DONE);
    assign stimulus_o   = stim_q;
    assign signature_o  = sig_q;
    assign pass_o       = pass_q;
    assign fail_phase_o = fail_q;

endmodule

// File: tb/tb_signature_test_sequencer.sv
// Scoreboard bench for signature_test_sequencer: a zero-latency instance with a
// mock/identity DUT and a two-cycle-latency instance with a registered DUT.
module tb_signature_test_sequencer;

    typedef struct {
        logic [15:0] sa;
        logic [15:0] sb;
        logic        pass;
        logic [1:0]  fail;
        int          busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        clear;
    logic        start0, start1;
    logic        mode;
    logic [7:0]  seed_a, seed_b;
    logic [15:0] golden_a, golden_b;
    logic [7:0]  dut_out0, dut_out1, d1_q, d2_q;

    logic        dclr0, busy0, done0, pass0;
    logic [7:0]  stim0;
    logic [15:0] sig0;
    logic [1:0]  fail0;
    logic        dclr1, busy1, done1, pass1;
    logic [7:0]  stim1;
    logic [15:0] sig1;
    logic [1:0]  fail1;

    int checks = 0;
    int failures = 0;
    exp_t q0[$];
    exp_t q1[$];

    logic        pb[2], pd[2], pdc[2];
    logic [15:0] psig[2], sa_seen[2];
    int          bcnt[2], crun[2];

    logic [15:0] ga, gb;

    always #5 clk = ~clk;

    assign dut_out0 = mode ? stim0 : 8'h00;
    assign dut_out1 = d2_q;
    always @(posedge clk) begin
        d1_q <= stim1;
        d2_q <= d1_q;
    end

    signature_test_sequencer #(.STIM_W(8), .CLR_CYCLES(2), .DUT_LATENCY(0)) u_dut0 (
        .clk_i(clk), .clear_i(clear), .start_i(start0),
        .seed_a_i(seed_a), .seed_b_i(seed_b), .golden_a_i(golden_a), .golden_b_i(golden_b),
        .dut_out_i(dut_out0), .dut_clear_o(dclr0), .stimulus_o(stim0), .signature_o(sig0),
        .busy_o(busy0), .done_o(done0), .pass_o(pass0), .fail_phase_o(fail0)
    );

    signature_test_sequencer #(.STIM_W(8), .CLR_CYCLES(2), .DUT_LATENCY(2)) u_dut1 (
        .clk_i(clk), .clear_i(clear), .start_i(start1),
        .seed_a_i(seed_a), .seed_b_i(seed_b), .golden_a_i(golden_a), .golden_b_i(golden_b),
        .dut_out_i(dut_out1), .dut_clear_o(dclr1), .stimulus_o(stim1), .signature_o(sig1),
        .busy_o(busy1), .done_o(done1), .pass_o(pass1), .fail_phase_o(fail1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] model_sig(input logic [7:0] seed, input bit ident);
        logic [15:0] s;
        logic [7:0]  lo;
        s = 16'h0000;
        for (int i = 0; i < 256; i++) begin
            lo = s[7:0] + (seed ^ (ident ? 8'(i) : 8'h00));
            s  = {s[14:8], lo, s[15]};
        end
        return s;
    endfunction

    task automatic mon_reset();
        for (int k = 0; k < 2; k++) begin
            pb[k] = 1'b0; pd[k] = 1'b0; pdc[k] = 1'b0;
            psig[k] = 16'h0; sa_seen[k] = 16'h0;
            bcnt[k] = 0; crun[k] = 0;
        end
    endtask

    task automatic mon_step(input int k, input logic b, input logic d, input logic dc,
                            input logic [15:0] sg, input logic ps, input logic [1:0] fp);
        exp_t e;
        if (b) bcnt[k]++;
        if (dc) crun[k]++;
        else if (pdc[k]) begin
            chk($sformatf("i%0d_dut_clear_len", k), crun[k], 2);
            crun[k] = 0;
        end
        if (dc && !pdc[k] && pb[k]) sa_seen[k] = psig[k];
        if (d && !pd[k]) begin
            if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                chk($sformatf("i%0d_unexpected_done", k), 1, 0);
            end else begin
                if (k == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("i%0d_busy_before_done", k), pb[k], 1);
                chk($sformatf("i%0d_busy_cycles", k), bcnt[k], e.busy);
                chk($sformatf("i%0d_sig_a", k), sa_seen[k], e.sa);
                chk($sformatf("i%0d_sig_b", k), sg, e.sb);
                chk($sformatf("i%0d_pass", k), ps, e.pass);
                chk($sformatf("i%0d_fail_phase", k), fp, e.fail);
            end
            bcnt[k] = 0;
        end
        pb[k] = b; pd[k] = d; pdc[k] = dc; psig[k] = sg;
    endtask

    always @(posedge clear) mon_reset();

    always @(negedge clk) begin
        if (!clear) begin
            mon_step(0, busy0, done0, dclr0, sig0, pass0, fail0);
            mon_step(1, busy1, done1, dclr1, sig1, pass1, fail1);
        end
    end

    task automatic pulse_start(input int k);
        @(negedge clk);
        if (k == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input int k, input int lim);
        int n = 0;
        while (((k == 0) ? done0 : done1) !== 1'b1 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("i%0d_done_in_time", k), (n < lim), 1);
    endtask

    task automatic wait_stim(input logic [7:0] v, input int lim);
        int n = 0;
        while (stim0 !== v && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("stim_reaches_%0h", v), (n < lim), 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dut_clear"}, dclr0, 0);
        chk({tag, "_stimulus"}, stim0, 0);
        chk({tag, "_signature"}, sig0, 0);
        chk({tag, "_busy"}, busy0, 0);
        chk({tag, "_done"}, done0, 0);
        chk({tag, "_pass"}, pass0, 0);
        chk({tag, "_fail_phase"}, fail0, 0);
    endtask

    initial begin
        mon_reset();
        clear = 1'b1; start0 = 1'b0; start1 = 1'b0; mode = 1'b0;
        seed_a = 8'h00; seed_b = 8'h00; golden_a = 16'h0000; golden_b = 16'h0000;
        repeat (3) @(negedge clk);
        chk_zero("rst");
        clear = 1'b0;

        // zero DUT, zero seeds and goldens: all-zero signatures, pass
        q0.push_back('{sa: 16'h0000, sb: 16'h0000, pass: 1'b1, fail: 2'b00, busy: 518});
        pulse_start(0);
        wait_done(0, 2000);

        // identity DUT, phase B golden corrupted in bit 0
        mode = 1'b1; seed_a = 8'hAA; seed_b = 8'hB8;
        ga = model_sig(8'hAA, 1'b1);
        gb = model_sig(8'hB8, 1'b1);
        golden_a = ga; golden_b = gb ^ 16'h0001;
        q0.push_back('{sa: ga, sb: gb, pass: 1'b0, fail: 2'b10, busy: 518});
        pulse_start(0);
        wait_done(0, 2000);

        // abort mid phase A, then restart
        pulse_start(0);
        wait_stim(8'h40, 300);
        clear = 1'b1;
        #1;
        chk_zero("abort");
        @(negedge clk);
        clear = 1'b0;
        q0.push_back('{sa: ga, sb: gb, pass: 1'b0, fail: 2'b10, busy: 518});
        pulse_start(0);
        wait_done(0, 2000);

        // start pulses while running must be ignored
        q0.push_back('{sa: ga, sb: gb, pass: 1'b0, fail: 2'b10, busy: 518});
        pulse_start(0);
        wait_stim(8'h10, 300);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_stim(8'hFF, 300);
        start0 = 1'b1;
        repeat (3) @(negedge clk);
        start0 = 1'b0;
        wait_done(0, 2000);

        // two-cycle-latency DUT, correct goldens
        golden_b = gb;
        q1.push_back('{sa: ga, sb: gb, pass: 1'b1, fail: 2'b00, busy: 522});
        pulse_start(1);
        wait_done(1, 2000);

        @(negedge clk);
        @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
